// File: rtl/led_panel_bcm.sv
// -----------------------------------------------------------------------------
// led_panel_bcm
//
// HUB75-style single-scan LED panel driver with binary-code-modulation colour
// depth and a built-in test-pattern generator.
//
// Each row is shifted out once per BCM plane. The display time of a plane
// doubles with its weight, so the MSB plane is shown longest. Row changes only
// ever happen while the panel is blanked.
//
// Build option:
//   LED_PANEL_BCM_EN  defined   : DEPTH planes per row (full BCM).
//   LED_PANEL_BCM_EN  undefined : one plane per row, fixed at the pattern MSB
//                                 (1-bit colour). Ports/parameters unchanged.
//
// Parameters:
//   COLS       columns shifted per row (>= 2)
//   ROW_BITS   row counter width
//   DEPTH      bits per colour channel = number of BCM planes (1..8)
//   PAUSE_UNIT display cycles of the LSB plane (>= 1)
//
// Ports:
//   clk        in   single clock
//   reset      in   synchronous, active-high reset
//   rowmax_in  in   index of the last row (sampled at the end of each row)
//   mode_in    in   test pattern select (registered at the start of each row)
//   red_out    out  column data, red
//   green_out  out  column data, green
//   blue_out   out  column data, blue
//   sclk_out   out  column shift clock (panel samples on the rising edge)
//   latch_out  out  active-low latch
//   blank_out  out  high = panel blanked
//   aclk_out   out  row advance pulse
//   arst_out   out  row reset to row 0
//   frame_out  out  one-cycle pulse at the start of each frame
// -----------------------------------------------------------------------------
// state    | meaning
// ---------+-------------------------------------------------------------------
// START    | row setup: drop row pulses, register mode, flag frame start
// SHIFT_LO | shift clock low, present column data for the current plane
// SHIFT_HI | shift clock high, panel samples; advance column or finish row
// LATCH    | pulse latch low for one cycle, clear dwell timer
// SHOW     | panel lit for PAUSE_UNIT * 2^plane cycles
// BLANK    | panel dark; next plane or go change row
// NEXTROW  | advance or wrap the row (and frame) counter while blanked
// -----------------------------------------------------------------------------
module led_panel_bcm #(
    parameter int COLS       = 64,
    parameter int ROW_BITS   = 6,
    parameter int DEPTH      = 4,
    parameter int PAUSE_UNIT = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ROW_BITS-1:0] rowmax_in,
    input  logic [1:0]          mode_in,
    output logic                red_out,
    output logic                green_out,
    output logic                blue_out,
    output logic                sclk_out,
    output logic                latch_out,
    output logic                blank_out,
    output logic                aclk_out,
    output logic                arst_out,
    output logic                frame_out
);

    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Must hold the longest dwell count, PAUSE_UNIT * 2^(DEPTH-1) - 1.
    localparam int DW = $clog2(PAUSE_UNIT * (2 ** (DEPTH - 1)) + 1);

    localparam logic [CW-1:0]       COL_LAST   = CW'(COLS - 1);
    localparam logic [CW-1:0]       COL_ONE    = CW'(1);
    localparam logic [PW-1:0]       PLANE_LAST = PW'(DEPTH - 1);
    localparam logic [PW-1:0]       PLANE_ONE  = PW'(1);
    localparam logic [ROW_BITS-1:0] ROW_ONE    = ROW_BITS'(1);
    localparam logic [DW-1:0]       DWELL_ONE  = DW'(1);
    localparam logic [7:0]          FRAME_ONE  = 8'd1;

`ifdef LED_PANEL_BCM_EN
    localparam logic [PW-1:0] PLANE_FIRST = '0;
`else
    // Single plane: always show the pattern MSB.
    localparam logic [PW-1:0] PLANE_FIRST = PLANE_LAST;
`endif

    typedef enum logic [2:0] {
        START    = 3'd0,
        SHIFT_LO = 3'd1,
        SHIFT_HI = 3'd2,
        LATCH    = 3'd3,
        SHOW     = 3'd4,
        BLANK    = 3'd5,
        NEXTROW  = 3'd6
    } state_t;

    // State and counters
    state_t              r_state;
    logic [CW-1:0]       r_col;
    logic [PW-1:0]       r_plane;
    logic [ROW_BITS-1:0] r_row;
    logic [7:0]          r_frame;
    logic [DW-1:0]       r_dwell;
    logic [1:0]          r_mode;

    // Registered panel outputs
    logic r_red;
    logic r_green;
    logic r_blue;
    logic r_sclk;
    logic r_latch;
    logic r_blank;
    logic r_aclk;
    logic r_arst;
    logic r_frame_pulse;

    // Next-state values
    state_t              w_state_nxt;
    logic [CW-1:0]       w_col_nxt;
    logic [PW-1:0]       w_plane_nxt;
    logic [ROW_BITS-1:0] w_row_nxt;
    logic [7:0]          w_frame_nxt;
    logic [DW-1:0]       w_dwell_nxt;
    logic [1:0]          w_mode_nxt;
    logic                w_red_nxt;
    logic                w_green_nxt;
    logic                w_blue_nxt;
    logic                w_sclk_nxt;
    logic                w_latch_nxt;
    logic                w_blank_nxt;
    logic                w_aclk_nxt;
    logic                w_arst_nxt;
    logic                w_frame_pulse_nxt;

    // Pattern generator: c, r, f all taken mod 2^DEPTH
    logic [DEPTH-1:0] w_c;
    logic [DEPTH-1:0] w_r;
    logic [DEPTH-1:0] w_f;
    logic [DEPTH-1:0] w_pat_r;
    logic [DEPTH-1:0] w_pat_g;
    logic [DEPTH-1:0] w_pat_b;
    logic [DW-1:0]    w_dwell_last;

    assign w_c = DEPTH'(r_col);
    assign w_r = DEPTH'(r_row);
    assign w_f = DEPTH'(r_frame);

    always_comb begin
        w_pat_r = '0;
        w_pat_g = '0;
        w_pat_b = '0;
        case (r_mode)
            2'd0: begin
                w_pat_r = '1;
                w_pat_g = '1;
                w_pat_b = '1;
            end
            2'd1: begin
                w_pat_r = w_c;
                w_pat_g = '0;
                w_pat_b = ~w_c;
            end
            2'd2: begin
                w_pat_r = w_r;
                w_pat_g = w_r;
                w_pat_b = w_r;
            end
            default: begin
                w_pat_r = w_c + w_f;
                w_pat_g = w_r;
                w_pat_b = '0;
            end
        endcase
    end

    // Plane p is shown for PAUSE_UNIT * 2^p cycles; the timer counts 0..last.
    assign w_dwell_last = DW'((PAUSE_UNIT << r_plane) - 1);

    always_comb begin
        w_state_nxt       = r_state;
        w_col_nxt         = r_col;
        w_plane_nxt       = r_plane;
        w_row_nxt         = r_row;
        w_frame_nxt       = r_frame;
        w_dwell_nxt       = r_dwell;
        w_mode_nxt        = r_mode;
        w_red_nxt         = r_red;
        w_green_nxt       = r_green;
        w_blue_nxt        = r_blue;
        w_sclk_nxt        = r_sclk;
        w_latch_nxt       = r_latch;
        w_blank_nxt       = r_blank;
        w_aclk_nxt        = r_aclk;
        w_arst_nxt        = r_arst;
        w_frame_pulse_nxt = r_frame_pulse;

        case (r_state)
            START: begin
                w_arst_nxt        = 1'b0;
                w_aclk_nxt        = 1'b0;
                w_col_nxt         = '0;
                w_plane_nxt       = PLANE_FIRST;
                w_blank_nxt       = 1'b1;
                w_latch_nxt       = 1'b1;
                // Mode is frozen per row so a row never mixes patterns.
                w_mode_nxt        = mode_in;
                w_frame_pulse_nxt = (r_row == '0);
                w_state_nxt       = SHIFT_LO;
            end
            SHIFT_LO: begin
                // Data changes with the falling shift clock so it is stable a
                // full cycle before the next rising edge.
                w_sclk_nxt        = 1'b0;
                w_red_nxt         = w_pat_r[r_plane];
                w_green_nxt       = w_pat_g[r_plane];
                w_blue_nxt        = w_pat_b[r_plane];
                w_frame_pulse_nxt = 1'b0;
                w_state_nxt       = SHIFT_HI;
            end
            SHIFT_HI: begin
                w_sclk_nxt = 1'b1;
                if (r_col == COL_LAST) begin
                    w_state_nxt = LATCH;
                end else begin
                    w_col_nxt   = r_col + COL_ONE;
                    w_state_nxt = SHIFT_LO;
                end
            end
            LATCH: begin
                w_sclk_nxt  = 1'b0;
                w_latch_nxt = 1'b0;
                w_red_nxt   = 1'b0;
                w_green_nxt = 1'b0;
                w_blue_nxt  = 1'b0;
                w_dwell_nxt = '0;
                w_state_nxt = SHOW;
            end
            SHOW: begin
                w_latch_nxt = 1'b1;
                w_blank_nxt = 1'b0;
                if (r_dwell == w_dwell_last) begin
                    w_state_nxt = BLANK;
                end else begin
                    w_dwell_nxt = r_dwell + DWELL_ONE;
                end
            end
            BLANK: begin
                w_blank_nxt = 1'b1;
`ifdef LED_PANEL_BCM_EN
                if (r_plane == PLANE_LAST) begin
                    w_state_nxt = NEXTROW;
                end else begin
                    w_plane_nxt = r_plane + PLANE_ONE;
                    w_col_nxt   = '0;
                    w_state_nxt = SHIFT_LO;
                end
`else
                w_state_nxt = NEXTROW;
`endif
            end
            NEXTROW: begin
                // >= rather than == so a lowered rowmax wraps immediately.
                if (r_row >= rowmax_in) begin
                    w_row_nxt   = '0;
                    w_arst_nxt  = 1'b1;
                    w_frame_nxt = r_frame + FRAME_ONE;
                end else begin
                    w_row_nxt  = r_row + ROW_ONE;
                    w_aclk_nxt = 1'b1;
                end
                w_state_nxt = START;
            end
            default: begin
                w_state_nxt = START;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= START;
            r_col         <= '0;
            r_plane       <= '0;
            r_row         <= '0;
            r_frame       <= '0;
            r_dwell       <= '0;
            r_mode        <= '0;
            r_red         <= 1'b0;
            r_green       <= 1'b0;
            r_blue        <= 1'b0;
            r_sclk        <= 1'b0;
            r_latch       <= 1'b1;
            r_blank       <= 1'b1;
            r_aclk        <= 1'b0;
            r_arst        <= 1'b1;
            r_frame_pulse <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_col         <= w_col_nxt;
            r_plane       <= w_plane_nxt;
            r_row         <= w_row_nxt;
            r_frame       <= w_frame_nxt;
            r_dwell       <= w_dwell_nxt;
            r_mode        <= w_mode_nxt;
            r_red         <= w_red_nxt;
            r_green       <= w_green_nxt;
            r_blue        <= w_blue_nxt;
            r_sclk        <= w_sclk_nxt;
            r_latch       <= w_latch_nxt;
            r_blank       <= w_blank_nxt;
            r_aclk        <= w_aclk_nxt;
            r_arst        <= w_arst_nxt;
            r_frame_pulse <= w_frame_pulse_nxt;
        end
    end

    assign red_out   = r_red;
    assign green_out = r_green;
    assign blue_out  = r_blue;
    assign sclk_out  = r_sclk;
    assign latch_out = r_latch;
    assign blank_out = r_blank;
    assign aclk_out  = r_aclk;
    assign arst_out  = r_arst;
    assign frame_out = r_frame_pulse;

endmodule

// File: tb/tb_led_panel_bcm.sv
// -----------------------------------------------------------------------------
// tb_led_panel_bcm
//
// Scoreboard bench for led_panel_bcm with COLS=4, ROW_BITS=3, DEPTH=2,
// PAUSE_UNIT=2. The stimulus process pushes the expected column bits, SHOW
// lengths, row pulses and frame periods into queues; a monitor pops and
// compares them as the DUT produces each event. Works with or without
// LED_PANEL_BCM_EN.
// -----------------------------------------------------------------------------
module tb_led_panel_bcm;

    localparam int COLS = 4;
    localparam int RB   = 3;
    localparam int D    = 2;
    localparam int PU   = 2;

`ifdef LED_PANEL_BCM_EN
    localparam int P_FIRST = 0;
    // START + NEXTROW + (8+1+2+1) + (8+1+4+1)
    localparam int ROW_CYC = 28;
`else
    localparam int P_FIRST = D - 1;
    // START + NEXTROW + (8+1+4+1)
    localparam int ROW_CYC = 16;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [RB-1:0] rowmax_in = 3'd2;
    logic [1:0]    mode_in = 2'd1;
    logic red_out, green_out, blue_out, sclk_out, latch_out;
    logic blank_out, aclk_out, arst_out, frame_out;

    led_panel_bcm #(
        .COLS(COLS), .ROW_BITS(RB), .DEPTH(D), .PAUSE_UNIT(PU)
    ) dut (
        .clk(clk), .reset(reset), .rowmax_in(rowmax_in), .mode_in(mode_in),
        .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
        .sclk_out(sclk_out), .latch_out(latch_out), .blank_out(blank_out),
        .aclk_out(aclk_out), .arst_out(arst_out), .frame_out(frame_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [2:0] q_rgb[$];
    int         q_show[$];
    logic [1:0] q_row[$];   // 2'b10 = aclk pulse, 2'b01 = arst pulse
    int         q_per[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference pattern: {R,G,B}, each D bits.
    function automatic logic [3*D-1:0] pat(input int mode, input int c, input int r, input int f);
        int m;
        int vr, vg, vb;
        m = 1 << D;
        vr = 0; vg = 0; vb = 0;
        case (mode)
            0: begin vr = m - 1; vg = m - 1; vb = m - 1; end
            1: begin vr = c % m; vg = 0; vb = (m - 1) - (c % m); end
            2: begin vr = r % m; vg = r % m; vb = r % m; end
            default: begin vr = (c + f) % m; vg = r % m; vb = 0; end
        endcase
        return {D'(vr), D'(vg), D'(vb)};
    endfunction

    task automatic push_row(input int mode, input int r, input int f);
        logic [3*D-1:0] v;
        for (int p = P_FIRST; p < D; p++) begin
            for (int c = 0; c < COLS; c++) begin
                v = pat(mode, c, r, f);
                q_rgb.push_back({v[2*D+p], v[D+p], v[p]});
            end
            q_show.push_back(PU << p);
        end
    endtask

    task automatic run_frames(input int mode, input int rmax, input int nfr, input int f0);
        for (int fr = 0; fr < nfr; fr++) begin
            for (int r = 0; r <= rmax; r++) begin
                push_row(mode, r, (f0 + fr) % 256);
                q_row.push_back((r < rmax) ? 2'b10 : 2'b01);
            end
            if (fr > 0) q_per.push_back(ROW_CYC * (rmax + 1));
        end
    endtask

    function automatic int pending();
        return q_rgb.size() + q_show.size() + q_row.size() + q_per.size();
    endfunction

    task automatic drain(input string nm, input int budget);
        int n;
        n = 0;
        while (pending() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (pending() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout pending=%0d expected=0", nm, pending());
        end
        q_rgb.delete(); q_show.delete(); q_row.delete(); q_per.delete();
    endtask

    task automatic enter_reset(input int mode, input int rmax);
        @(negedge clk); #1;
        reset = 1'b1;
        mode_in = 2'(mode);
        rowmax_in = RB'(rmax);
        repeat (3) @(negedge clk);
    endtask

    task automatic release_reset();
        #1 reset = 1'b0;
    endtask

    // {r,g,b,sclk,latch,blank,aclk,arst,frame}
    function automatic int outs();
        return int'({red_out, green_out, blue_out, sclk_out, latch_out,
                     blank_out, aclk_out, arst_out, frame_out});
    endfunction

    // ---------------- monitor ----------------
    initial begin
        logic p_sclk, p_blank;
        int blank_run, latch_run, cyc, last_f;
        bit have_last;
        logic [2:0] e_rgb;
        logic [1:0] e_row;
        p_sclk = 1'b0; p_blank = 1'b1;
        blank_run = 0; latch_run = 0; cyc = 0; last_f = 0; have_last = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                blank_run = 0;
                latch_run = 0;
                have_last = 0;
            end else begin
                if (sclk_out && !p_sclk && q_rgb.size() != 0) begin
                    e_rgb = q_rgb.pop_front();
                    chk("col_rgb", int'({red_out, green_out, blue_out}), int'(e_rgb));
                end
                if (!blank_out) begin
                    blank_run++;
                end else if (!p_blank && blank_run > 0) begin
                    if (q_show.size() != 0) chk("show_len", blank_run, q_show.pop_front());
                    blank_run = 0;
                end
                if (!latch_out) begin
                    latch_run++;
                end else if (latch_run > 0) begin
                    chk("latch_len", latch_run, 1);
                    latch_run = 0;
                end
                if ((aclk_out || arst_out) && q_row.size() != 0) begin
                    e_row = q_row.pop_front();
                    chk("row_pulse", int'({aclk_out, arst_out}), int'(e_row));
                end
                if (frame_out) begin
                    if (have_last && q_per.size() != 0)
                        chk("frame_period", cyc - last_f, q_per.pop_front());
                    last_f = cyc;
                    have_last = 1;
                end
            end
            p_sclk = sclk_out;
            p_blank = blank_out;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int n, cnt;

        // Reset state, then mode 1 / rowmax 2 for two frames.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", outs(), int'(9'b000_0_1_1_0_1_0));
        run_frames(1, 2, 2, 0);
        release_reset();
        @(negedge clk);
        chk("first_frame_pulse", int'({frame_out, arst_out, sclk_out}), int'(3'b100));
        drain("mode1", 2000);

        // Mode 3, rowmax 1: frame counter feeds R; run past the 255->0 wrap.
        enter_reset(3, 1);
        run_frames(3, 1, 258, 0);
        release_reset();
        drain("mode3_wrap", 20000);

        // Mode 0, single row per frame: all bits set.
        enter_reset(0, 0);
        run_frames(0, 0, 3, 0);
        release_reset();
        drain("mode0", 1000);

        // Lower rowmax from 5 to 1 while row 3 is being shown.
        enter_reset(2, 5);
        for (int r = 0; r < 4; r++) push_row(2, r, 0);
        q_row.push_back(2'b10); q_row.push_back(2'b10);
        q_row.push_back(2'b10); q_row.push_back(2'b01);
        push_row(2, 0, 1); push_row(2, 1, 1);
        q_row.push_back(2'b10); q_row.push_back(2'b01);
        release_reset();
        n = 0; cnt = 0;
        while (cnt < 3 && n < 500) begin
            @(negedge clk);
            n++;
            if (aclk_out) cnt++;
        end
        chk("row3_reached", cnt, 3);
        #1 rowmax_in = 3'd1;
        drain("rowmax_change", 2000);

        // Reset asserted during SHOW.
        n = 0;
        while (blank_out && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("in_show", int'(blank_out), 0);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("reset_in_show", outs(), int'(9'b000_0_1_1_0_1_0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
